// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared constants and state encoding for the register-bank write path
package gpr_pkg;
    localparam int GPR_DATA_WIDTH = 8;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int GPR_COUNT      = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_IO  = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner select from a request mask and pointer
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        int j;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        // Scan farthest offset first so the nearest hit at/after the pointer wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (mask_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - round-robin lockable arbiter for the GPR bank write port; GPR_WRITE_FWD_EN adds forwarding outputs
module gpr_write_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int LOCK_MAX   = 2
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [(2**ADDR_WIDTH)-1:0]       wr_en,
    output logic [DATA_WIDTH-1:0]            wr_data,
`ifdef GPR_WRITE_FWD_EN
    output logic                             fwd_valid,
    output logic [ADDR_WIDTH-1:0]            fwd_addr,
    output logic [DATA_WIDTH-1:0]            fwd_data,
`endif
    output logic                             busy
);
    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = $clog2(LOCK_MAX + 1);
    localparam int NREG = 2 ** ADDR_WIDTH;

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NREG-1:0]         wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
`ifdef GPR_WRITE_FWD_EN
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
`endif

    logic [NUM_REQ-1:0]      eligible;
    logic                    pick_valid;
    logic [IW-1:0]           pick_idx;
    logic                    grant;
    logic [IW-1:0]           sel;

    // The requester holding this cycle's grant must renew req before it can win again.
    assign eligible = req & ~gnt_q;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .mask_i  (eligible),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        grant     = 1'b0;
        sel       = pick_idx;
`ifdef GPR_WRITE_FWD_EN
        addr_d    = addr_q;
`endif
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (req_lock[pick_idx] && (LOCK_MAX > 1)) begin
                        state_d = LOCKED;
                        cnt_d   = CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    grant = 1'b1;
                    sel   = owner_q;
                    cnt_d = cnt_q + 1'b1;
                    if (!req_lock[owner_q] || (int'(cnt_q) + 1 >= LOCK_MAX)) begin
                        state_d = ARB;
                    end
                end else begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase

        if (grant) begin
            gnt_d[sel] = 1'b1;
            wr_data_d  = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
            wr_en_d[req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
`ifdef GPR_WRITE_FWD_EN
            addr_d     = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
`endif
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
`ifdef GPR_WRITE_FWD_EN
            addr_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
`ifdef GPR_WRITE_FWD_EN
            addr_q    <= addr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == LOCKED);

`ifdef GPR_WRITE_FWD_EN
    assign fwd_valid = |gnt_q;
    assign fwd_addr  = fwd_valid ? addr_q : '0;
    assign fwd_data  = fwd_valid ? wr_data_q : '0;
`endif
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb/tb_gpr_write_arbiter.sv - directed scoreboard bench for gpr_write_arbiter
`timescale 1ns/1ps
module tb_gpr_write_arbiter;
    import gpr_pkg::*;

    localparam int NR   = 3;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              clr_n;
    logic [NR-1:0]     req, req_lock, gnt;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NREG-1:0]   wr_en;
    logic [DW-1:0]     wr_data;
    logic              busy;
`ifdef GPR_WRITE_FWD_EN
    logic              fwd_valid;
    logic [AW-1:0]     fwd_addr;
    logic [DW-1:0]     fwd_data;
`endif

    logic [AW-1:0]     a [NR];
    logic [DW-1:0]     d [NR];
    logic [DW-1:0]     bank [NREG];

    typedef struct {
        int            w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (wr_en[i] === 1'b1) bank[i] <= wr_data;
        end
    end

    gpr_write_arbiter dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .req      (req),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef GPR_WRITE_FWD_EN
        .fwd_valid(fwd_valid),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
`endif
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of requests, queue the expected grant, then compare after the edge.
    task automatic cyc(input logic [NR-1:0] r, input logic [NR-1:0] l, input int w,
                       input logic bz, input string tag);
        exp_t e;
        logic [31:0] eg, ee;
        req      = r;
        req_lock = l;
        e.w      = w;
        e.addr   = '0;
        e.data   = '0;
        e.busy   = bz;
        if (w >= 0) begin
            e.addr = a[w];
            e.data = d[w];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        eg = 0;
        ee = 0;
        if (e.w >= 0) begin
            eg = 32'(1) << e.w;
            ee = 32'(1) << e.addr;
        end
        chk({tag, ".gnt"},   32'(gnt), eg);
        chk({tag, ".wr_en"}, wr_en,    ee);
        chk({tag, ".busy"},  32'(busy), 32'(e.busy));
        if (e.w >= 0) chk({tag, ".wr_data"}, 32'(wr_data), 32'(e.data));
`ifdef GPR_WRITE_FWD_EN
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), (e.w >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".fwd_addr"},  32'(fwd_addr),  32'(e.addr));
        chk({tag, ".fwd_data"},  32'(fwd_data),  32'(e.data));
`endif
    endtask

    task automatic do_reset(input string tag);
        #3;
        clr_n = 1'b0;
        #1;
        chk({tag, ".gnt"},     32'(gnt),     32'd0);
        chk({tag, ".wr_en"},   wr_en,        32'd0);
        chk({tag, ".wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, ".busy"},    32'(busy),    32'd0);
        req      = '0;
        req_lock = '0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n    = 1'b0;
        req      = '0;
        req_lock = '0;
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        @(posedge clk);
        #1;
        chk("rst.gnt",     32'(gnt),     32'd0);
        chk("rst.wr_en",   wr_en,        32'd0);
        chk("rst.wr_data", 32'(wr_data), 32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) cyc(3'b000, 3'b000, -1, 1'b0, "idle");

        a[REQ_LSU] = 5'd17;
        d[REQ_LSU] = 8'hA5;
        cyc(3'b010, 3'b000, REQ_LSU, 1'b0, "single");
        cyc(3'b000, 3'b000, -1, 1'b0, "single_after");
        chk("r17", 32'(bank[17]), 32'hA5);
        chk("single_hold", 32'(wr_data), 32'hA5);

        do_reset("rst_rr");
        a[0] = 5'd4;
        a[1] = 5'd8;
        a[2] = 5'd12;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++) d[i] = 8'(16 * k + i);
            cyc(3'b111, 3'b000, k % 3, 1'b0, "rr");
        end
        cyc(3'b000, 3'b000, -1, 1'b0, "rr_end");
        chk("r12", 32'(bank[12]), 32'h52);

        a[REQ_ALU] = 5'd24;
        d[REQ_ALU] = 8'h24;
        a[REQ_IO]  = 5'd30;
        d[REQ_IO]  = 8'h77;
        cyc(3'b101, 3'b001, REQ_ALU, 1'b1, "pair1");
        a[REQ_ALU] = 5'd25;
        d[REQ_ALU] = 8'h25;
        cyc(3'b101, 3'b001, REQ_ALU, 1'b0, "pair2");
        cyc(3'b100, 3'b000, REQ_IO, 1'b0, "pair_io");
        cyc(3'b000, 3'b000, -1, 1'b0, "pair_end");
        chk("r24", 32'(bank[24]), 32'h24);
        chk("r25", 32'(bank[25]), 32'h25);
        chk("r30", 32'(bank[30]), 32'h77);

        a[0] = 5'd10; d[0] = 8'hA0;
        a[1] = 5'd11; d[1] = 8'hB1;
        a[2] = 5'd12; d[2] = 8'hC2;
        cyc(3'b111, 3'b001, 0, 1'b1, "lim1");
        cyc(3'b111, 3'b001, 0, 1'b0, "lim2");
        cyc(3'b111, 3'b001, 1, 1'b0, "lim3");
        cyc(3'b111, 3'b001, 2, 1'b0, "lim4");
        cyc(3'b000, 3'b000, -1, 1'b0, "lim_end");

        cyc(3'b010, 3'b010, 1, 1'b1, "early1");
        cyc(3'b100, 3'b000, -1, 1'b0, "early_gap");
        cyc(3'b100, 3'b000, 2, 1'b0, "early_arb");
        cyc(3'b000, 3'b000, -1, 1'b0, "early_end");

        a[REQ_ALU] = 5'd3;
        d[REQ_ALU] = 8'h3C;
        cyc(3'b001, 3'b000, REQ_ALU, 1'b0, "fwd");
        cyc(3'b000, 3'b000, -1, 1'b0, "fwd_idle");
        chk("r3", 32'(bank[3]), 32'h3C);

        cyc(3'b010, 3'b010, 1, 1'b1, "midlock");
        do_reset("rst_lock");
        cyc(3'b000, 3'b000, -1, 1'b0, "post_rst");
        cyc(3'b111, 3'b000, 0, 1'b0, "ptr_reset");
        cyc(3'b000, 3'b000, -1, 1'b0, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
